// File: rtl/stopwatch_sequencer.sv
// stopwatch_sequencer
//
// Single-clock controller for the stopwatch seconds/minutes counters. It
// synchronises the board buttons and switches, debounces the pause button,
// owns the run/pause state, and divides the master clock into a 2 Hz adjust
// tick and a 1 Hz run tick. It drives one-cycle increment and clear strobes
// to the counter datapath.
//
// Parameters
//   CLK_HZ     master clock frequency (even, >= 4)
//   DB_CYCLES  cycles a changed, synchronised pause level must persist
//
// Ports
//   clk      in   master clock, rising edge
//   rst      in   asynchronous active-high reset
//   pause    in   raw pause button (asynchronous)
//   clr      in   raw clear button (asynchronous)
//   adj      in   adjust-mode switch, 1 = adjust
//   sel      in   adjust target, 0 = minutes, 1 = seconds
//   sec_max  in   seconds counter holds 59
//   inc_sec  out  one-cycle seconds increment strobe
//   inc_min  out  one-cycle minutes increment strobe
//   clr_cnt  out  one-cycle clear strobe to both counters
//   paused   out  1 = frozen in run mode
//   adj_min  out  1 = adjusting minutes
//   blink    out  blank control for the digit being adjusted
//
// Build option
//   STOPWATCH_BLINK_EN  when defined, blink toggles on every 2 Hz tick while
//                       in adjust mode; otherwise blink is tied low.

module stopwatch_sequencer #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pause,
  input  logic clr,
  input  logic adj,
  input  logic sel,
  input  logic sec_max,
  output logic inc_sec,
  output logic inc_min,
  output logic clr_cnt,
  output logic paused,
  output logic adj_min,
  output logic blink
);

  localparam int unsigned HalfHz = CLK_HZ / 2;
  localparam int unsigned DivW   = (HalfHz > 1) ? $clog2(HalfHz) : 1;
  localparam int unsigned DbW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(HalfHz - 1);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DB_CYCLES - 1);

  // Operating modes, decoded from the synchronised adj switch and paused.
  localparam logic [1:0] ModeRun    = 2'd0;
  localparam logic [1:0] ModePaused = 2'd1;
  localparam logic [1:0] ModeAdjust = 2'd2;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers, bit order {sel, adj, clr, pause}
  // ---------------------------------------------------------------------------
  logic [3:0] sync_meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= {sel, adj, clr, pause};
      sync_q      <= sync_meta_q;
    end
  end

  logic pause_s;
  logic clr_s;
  logic adj_s;
  logic sel_s;

  assign pause_s = sync_q[0];
  assign clr_s   = sync_q[1];
  assign adj_s   = sync_q[2];
  assign sel_s   = sync_q[3];

  // ---------------------------------------------------------------------------
  // Clear edge detect; repeat clears are harmless so no debounce
  // ---------------------------------------------------------------------------
  logic clr_prev_q;
  logic clr_rise;

  assign clr_rise = clr_s & ~clr_prev_q;

  // ---------------------------------------------------------------------------
  // Pause debounce and toggle
  // ---------------------------------------------------------------------------
  logic [DbW-1:0] db_cnt_q;
  logic [DbW-1:0] db_cnt_d;
  logic           pb_q;
  logic           pb_d;
  logic           pb_prev_q;
  logic           paused_q;
  logic           paused_d;

  always_comb begin
    db_cnt_d = '0;
    pb_d     = pb_q;
    if (pause_s != pb_q) begin
      // Accept the new level only after it has persisted DB_CYCLES cycles.
      if (db_cnt_q == DbLast) begin
        pb_d = pause_s;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  // Only a press (accepted 0->1) toggles; release and hold do nothing.
  assign paused_d = paused_q ^ (pb_q & ~pb_prev_q);

  // ---------------------------------------------------------------------------
  // Tick divider: tick2 at 2 Hz, tick1 on every other tick2
  // ---------------------------------------------------------------------------
  logic [DivW-1:0] div_q;
  logic [DivW-1:0] div_d;
  logic            phase_q;
  logic            phase_d;
  logic            tick2;
  logic            tick1;

  assign tick2 = (div_q == DivLast);
  assign tick1 = tick2 & phase_q;

  always_comb begin
    if (clr_rise) begin
      // Restart timing so the next full second starts at the clear.
      div_d   = '0;
      phase_d = 1'b0;
    end else begin
      div_d   = tick2 ? '0 : div_q + DivW'(1);
      phase_d = phase_q ^ tick2;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode decode and strobe generation
  // ---------------------------------------------------------------------------
  logic [1:0] mode;
  logic       inc_sec_q;
  logic       inc_sec_d;
  logic       inc_min_q;
  logic       inc_min_d;
  logic       clr_cnt_q;
  logic       adj_min_q;
  logic       adj_min_d;

  always_comb begin
    if (adj_s) begin
      mode = ModeAdjust;
    end else if (paused_q) begin
      mode = ModePaused;
    end else begin
      mode = ModeRun;
    end
  end

  always_comb begin
    inc_sec_d = 1'b0;
    inc_min_d = 1'b0;
    // A clear in the same cycle as a tick suppresses the increment.
    if (!clr_rise) begin
      case (mode)
        ModeRun: begin
          inc_sec_d = tick1;
          inc_min_d = tick1 & sec_max;
        end
        ModePaused: begin
          inc_sec_d = 1'b0;
          inc_min_d = 1'b0;
        end
        ModeAdjust: begin
          // Direct digit adjust: no carry into minutes.
          inc_sec_d = tick2 & sel_s;
          inc_min_d = tick2 & ~sel_s;
        end
        default: begin
          inc_sec_d = 1'b0;
          inc_min_d = 1'b0;
        end
      endcase
    end
  end

  assign adj_min_d = adj_s & ~sel_s;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_prev_q <= 1'b0;
      db_cnt_q   <= '0;
      pb_q       <= 1'b0;
      pb_prev_q  <= 1'b0;
      paused_q   <= 1'b0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      inc_sec_q  <= 1'b0;
      inc_min_q  <= 1'b0;
      clr_cnt_q  <= 1'b0;
      adj_min_q  <= 1'b0;
    end else begin
      clr_prev_q <= clr_s;
      db_cnt_q   <= db_cnt_d;
      pb_q       <= pb_d;
      pb_prev_q  <= pb_q;
      paused_q   <= paused_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      inc_sec_q  <= inc_sec_d;
      inc_min_q  <= inc_min_d;
      clr_cnt_q  <= clr_rise;
      adj_min_q  <= adj_min_d;
    end
  end

  assign inc_sec = inc_sec_q;
  assign inc_min = inc_min_q;
  assign clr_cnt = clr_cnt_q;
  assign paused  = paused_q;
  assign adj_min = adj_min_q;

  // ---------------------------------------------------------------------------
  // Adjust-digit blink
  // ---------------------------------------------------------------------------
`ifdef STOPWATCH_BLINK_EN
  logic blink_q;
  logic blink_d;

  assign blink_d = adj_s ? (blink_q ^ tick2) : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Self-checking bench for stopwatch_sequencer with CLK_HZ=8, DB_CYCLES=4.
// Expected strobes are queued with the cycle they must appear in; a monitor
// pops and compares each time a strobe is seen. Level outputs are checked
// directly against hand-computed values.

module tb_stopwatch_sequencer;

`ifdef STOPWATCH_BLINK_EN
  localparam bit BlinkEn = 1'b1;
`else
  localparam bit BlinkEn = 1'b0;
`endif

  logic clk;
  logic rst;
  logic pause;
  logic clr;
  logic adj;
  logic sel;
  logic sec_max;
  logic inc_sec;
  logic inc_min;
  logic clr_cnt;
  logic paused;
  logic adj_min;
  logic blink;

  stopwatch_sequencer #(
    .CLK_HZ   (8),
    .DB_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pause  (pause),
    .clr    (clr),
    .adj    (adj),
    .sel    (sel),
    .sec_max(sec_max),
    .inc_sec(inc_sec),
    .inc_min(inc_min),
    .clr_cnt(clr_cnt),
    .paused (paused),
    .adj_min(adj_min),
    .blink  (blink)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index: number of rising edges since reset release.
  int cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int cyc;
    bit s;
    bit m;
    bit c;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;

  task automatic expect_strobe(input int c, input bit s, input bit m, input bit k);
    exp_t e;
    e.cyc = c;
    e.s   = s;
    e.m   = m;
    e.c   = k;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && (inc_sec || inc_min || clr_cnt)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL strobe_unexpected: got sec=%0b min=%0b clr=%0b at cycle %0d, required none",
                 inc_sec, inc_min, clr_cnt, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.s != inc_sec || e.m != inc_min || e.c != clr_cnt) begin
          n_err++;
          $display("FAIL strobe: got sec=%0b min=%0b clr=%0b at cycle %0d, required sec=%0b min=%0b clr=%0b at cycle %0d",
                   inc_sec, inc_min, clr_cnt, cyc, e.s, e.m, e.c, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic drain(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d strobes still outstanding (next at cycle %0d), required 0",
               name, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  // Advance to 1 ns after rising edge n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    pause   = 1'b0;
    clr     = 1'b0;
    adj     = 1'b0;
    sel     = 1'b0;
    sec_max = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_inc_sec"}, inc_sec, 0);
    check({name, "_inc_min"}, inc_min, 0);
    check({name, "_clr_cnt"}, clr_cnt, 0);
    check({name, "_paused"},  paused,  0);
    check({name, "_adj_min"}, adj_min, 0);
    check({name, "_blink"},   blink,   0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    pause   = 1'b0;
    clr     = 1'b0;
    adj     = 1'b0;
    sel     = 1'b0;
    sec_max = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Run: seconds strobe every 8 cycles, never a minutes strobe.
    expect_strobe(8, 1, 0, 0);
    expect_strobe(16, 1, 0, 0);
    expect_strobe(24, 1, 0, 0);
    expect_strobe(32, 1, 0, 0);
    goto(36);
    check("run_paused", paused, 0);
    drain("run");

    // Carry: sec_max during the tick1 cycle gives both strobes together.
    do_reset();
    expect_strobe(8, 1, 1, 0);
    expect_strobe(16, 1, 0, 0);
    goto(7);
    sec_max = 1'b1;
    goto(8);
    sec_max = 1'b0;
    goto(20);
    drain("carry");

    // Pause: press before edge 3, paused at cycle 9; strobes stop.
    do_reset();
    expect_strobe(8, 1, 0, 0);
    goto(2);
    pause = 1'b1;
    goto(8);
    check("pause_before", paused, 0);
    goto(9);
    check("pause_after", paused, 1);
    goto(12);
    pause = 1'b0;
    // Two-cycle glitch must be rejected.
    goto(30);
    pause = 1'b1;
    goto(32);
    pause = 1'b0;
    goto(45);
    check("pause_glitch", paused, 1);
    // Second press resumes; run tick at 55 gives strobe at 56.
    pause = 1'b1;
    expect_strobe(56, 1, 0, 0);
    expect_strobe(64, 1, 0, 0);
    goto(51);
    check("resume_before", paused, 1);
    goto(52);
    check("resume_after", paused, 0);
    goto(55);
    pause = 1'b0;
    goto(66);
    drain("pause");

    // Adjust minutes, then seconds, then back to run.
    do_reset();
    adj = 1'b1;
    expect_strobe(4, 0, 1, 0);
    expect_strobe(8, 0, 1, 0);
    expect_strobe(12, 0, 1, 0);
    expect_strobe(16, 0, 1, 0);
    expect_strobe(20, 0, 1, 0);
    expect_strobe(24, 1, 0, 0);
    expect_strobe(28, 1, 0, 0);
    expect_strobe(32, 1, 0, 0);
    expect_strobe(40, 1, 0, 0);
    goto(2);
    check("adj_min_before", adj_min, 0);
    goto(3);
    check("adj_min_on", adj_min, 1);
    goto(4);
    check("blink_4", blink, BlinkEn ? 1 : 0);
    goto(8);
    check("blink_8", blink, 0);
    goto(12);
    check("blink_12", blink, BlinkEn ? 1 : 0);
    goto(20);
    sel = 1'b1;
    goto(22);
    check("adj_min_sel_before", adj_min, 1);
    goto(23);
    check("adj_min_sel_after", adj_min, 0);
    goto(32);
    adj = 1'b0;
    goto(36);
    check("blink_off", blink, 0);
    goto(42);
    drain("adjust");

    // Clear: pulse at 12 restarts timing; second clear lands on a tick1.
    do_reset();
    expect_strobe(8, 1, 0, 0);
    expect_strobe(12, 0, 0, 1);
    expect_strobe(20, 1, 0, 0);
    expect_strobe(28, 0, 0, 1);
    expect_strobe(36, 1, 0, 0);
    goto(9);
    clr = 1'b1;
    goto(11);
    clr = 1'b0;
    goto(25);
    clr = 1'b1;
    goto(27);
    clr = 1'b0;
    goto(30);
    check("clr_paused", paused, 0);
    goto(38);
    drain("clear");

    // Asynchronous reset while a strobe is high.
    do_reset();
    adj = 1'b1;
    expect_strobe(4, 0, 1, 0);
    goto(8);
    check("async_pre_inc_min", inc_min, 1);
    check("async_pre_adj_min", adj_min, 1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async");
    do_reset();
    drain("async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
